// File: rtl/uart_tx_periph_if.sv
//------------------------------------------------------------------------------
// uart_tx_periph_if : data-bus slave port of the UART transmitter peripheral
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_periph_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/uart_tx_periph.sv
//------------------------------------------------------------------------------
// uart_tx_periph : memory-mapped 8N1 UART transmitter with a write FIFO
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_periph #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  uart_tx_periph_if.slave    bus,
  output logic               tx,
  output logic               tx_busy,
  output logic               irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] C_BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [AW:0]   C_DEPTH       = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_wr_txdata;
  logic            w_wr_status;
  logic            w_push;
  logic            w_pop;
  logic            w_baud_done;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_wr_txdata = bus.sel & bus.we & (bus.addr == 2'd0);
  assign w_wr_status = bus.sel & bus.we & (bus.addr == 2'd1);
  assign w_push      = w_wr_txdata & ~w_full;
  assign w_baud_done = (r_baud == '0);
  // Must match exactly the cases where the FSM loads r_shift from the FIFO head.
  assign w_pop       = ~w_empty & ((r_state == ST_IDLE) |
                                   ((r_state == ST_STOP) & w_baud_done));

  assign tx_busy   = (r_state != ST_IDLE) | ~w_empty;
  assign irq_empty = (r_state == ST_IDLE) & w_empty;

  assign w_status = {16'h0000, 8'(r_count), 4'h0, r_overflow, w_empty, w_full, tx_busy};
  assign w_unused = ^bus.wdata[31:8];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      // Full is judged on the pre-edge count, so a same-edge pop never rescues the byte.
      if (w_wr_txdata & w_full) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status & bus.wdata[3]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata <= 32'h0;
    end else if (bus.sel & ~bus.we) begin
      bus.rdata <= (bus.addr == 2'd1) ? w_status : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      tx        <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= C_BAUD_RELOAD;
            tx      <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud    <= C_BAUD_RELOAD;
            r_bit_idx <= 3'd0;
            tx        <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= C_BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              tx      <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              tx        <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            if (!w_empty) begin
              r_shift <= r_mem[r_rd_ptr];
              r_baud  <= C_BAUD_RELOAD;
              tx      <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
